apb_nslave_bridge: RTL and testbench
====================================

Name: apb_nslave_bridge

Overview:
- Parametrised APB master and interconnect: the next generation of the two-slave GPIO/UART APB top.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Decodes the address to one of SLAVES_NUM slaves and returns read data and error status on a one-cycle response strobe.
- Replaces the fixed PSEL1/PSEL2 wiring and the select-driven PRDATA/PREADY muxing with address decode and per-slave PSLVERR collection.

Parameters:
- DATA_WIDTH, 32, width of PWDATA, PRDATA and the command data.
- ADDRESS_WIDTH, 32, width of PADDR and cmd_addr.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- SLAVES_NUM, 4, number of slaves; legal range 1..2^SEL_BITS.
- SEL_LSB, 12, lowest address bit of the slave-index field.
- SEL_BITS, 4, width of the slave-index field.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort (only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock; every flop updates on the rising edge.
- PRESET  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- PADDR  out  ADDRESS_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  STRB_WIDTH  APB strobes.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PSEL  out  SLAVES_NUM  one-hot slave select.
- PRDATA_BUS  in  SLAVES_NUM*DATA_WIDTH  concatenated slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  SLAVES_NUM  per-slave ready.
- PSLVERR  in  SLAVES_NUM  per-slave error.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FSM state is IDLE.
- Reset asserted mid-transfer: the bus drops on the next edge; no rsp_valid is issued for the aborted command.
- FSM states are IDLE, SETUP and ACCESS.
- cmd_ready = 1 only in IDLE.
- Command accepted at edge T:
  - cmd_addr, cmd_write, cmd_wdata and cmd_strb are registered.
  - slave index idx = cmd_addr[SEL_LSB +: SEL_BITS].
- Decode miss (idx >= SLAVES_NUM):
  - No PSEL is asserted and the FSM stays in IDLE.
  - rsp_valid = 1 and rsp_err = 1 in cycle T+1.
- Decode hit, SETUP (cycle T+1): PSEL[idx] = 1, PENABLE = 0, PADDR/PWRITE/PWDATA/PSTRB valid.
- Reads drive PSTRB = 0 and PWDATA = 0.
- ACCESS (cycle T+2 onward): PENABLE = 1. All bus outputs are held stable until completion.
- Completion: the edge on which PREADY[idx] = 1 during ACCESS.
  - PSEL and PENABLE drop to 0; FSM returns to IDLE.
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = PSLVERR[idx].
  - rsp_rdata = read ? slice idx of PRDATA_BUS : 0.
  - rsp_rdata is forced to 0 when rsp_err = 1.
- Minimum latency: acceptance to rsp_valid is 3 cycles with zero wait states. Each wait state adds 1.
- Back-to-back: a new command can be accepted in the same cycle rsp_valid is high. No pipelining; at most one outstanding command.
- PREADY, PSLVERR and PRDATA of unselected slaves are ignored.
- PSLVERR is sampled only at completion.
- rsp_rdata and rsp_err hold their value until the next response; only rsp_valid pulses.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY[idx].
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL and PENABLE drop, FSM goes to IDLE.
  - Response: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY arriving in the same cycle as the terminal count wins, and the transfer completes normally.
- Undefined: no counter is built; ACCESS waits indefinitely.

Test Plan:
- Write to slave 1, addr 0x0000_1004, data 0xA5A5_0F0F, strb 0xF, PREADY tied high -> PSEL = 0b0010; PENABLE high exactly 1 cycle; rsp_valid 3 cycles after accept; rsp_err = 0; rsp_rdata = 0.
- Read from slave 2, addr 0x0000_2000, slave 2 PRDATA = 0xDEAD_BEEF, PREADY delayed 2 cycles -> PADDR/PSEL stable across ACCESS; rsp_rdata = 0xDEAD_BEEF at 5 cycles after accept.
- Read with PSLVERR[0] = 1 at completion -> rsp_err = 1; rsp_rdata = 0.
- Command to addr 0x0000_7000 with SLAVES_NUM = 4 -> no PSEL; rsp_valid with rsp_err = 1 at T+1.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, PREADY stuck low -> abort after 16 ACCESS cycles; rsp_err = 1. A second run raising PREADY on cycle 16 -> normal completion.
- PRESET raised during ACCESS -> all bus outputs 0 and cmd_ready = 1 on the next edge; no rsp_valid; a following write completes normally.

Source files
------------

// File: rtl/apb_nslave_bridge.sv
// ---------------------------------------------------------------------------
// apb_nslave_bridge
//
// Purpose:
//   APB master plus address-decoding interconnect for SLAVES_NUM slaves.
//   The bridge accepts one read or write command at a time on a valid/ready
//   port. It decodes the slave index from cmd_addr[SEL_LSB +: SEL_BITS] and
//   runs the APB SETUP/ACCESS sequence on the selected slave. It returns read
//   data and error status on a one-cycle response strobe. An index with no
//   slave behind it is answered at once with an error and never reaches the
//   bus.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_write, cmd_addr,    command fields, registered on acceptance
//   cmd_wdata, cmd_strb
//   rsp_valid               one-cycle response pulse
//   rsp_rdata, rsp_err      response payload; held until the next response
//   PADDR, PWDATA, PSTRB,   APB master outputs
//   PWRITE, PENABLE, PSEL
//   PRDATA_BUS              concatenated slave read data, slave i at
//                           [i*DATA_WIDTH +: DATA_WIDTH]
//   PREADY, PSLVERR         per-slave ready and error
//
// Build options:
//   APB_TIMEOUT_EN  when defined, an ACCESS phase that sees no PREADY for
//                   TIMEOUT_CYCLES cycles is aborted with an error response.
//                   When undefined, no counter exists and ACCESS waits for
//                   PREADY indefinitely.
// ---------------------------------------------------------------------------
module apb_nslave_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int SLAVES_NUM     = 4,
    parameter int SEL_LSB        = 12,
    parameter int SEL_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,

    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [STRB_WIDTH-1:0]            cmd_strb,

    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,

    output logic [ADDRESS_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    output logic                             PWRITE,
    output logic                             PENABLE,
    output logic [SLAVES_NUM-1:0]            PSEL,
    input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA_BUS,
    input  logic [SLAVES_NUM-1:0]            PREADY,
    input  logic [SLAVES_NUM-1:0]            PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                     state_q, state_d;

    logic [ADDRESS_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
    logic                       pwrite_q, pwrite_d;
    logic [SEL_BITS-1:0]        selIdx_q, selIdx_d;

    logic                       rspValid_q, rspValid_d;
    logic                       rspErr_q, rspErr_d;
    logic [DATA_WIDTH-1:0]      rspRdata_q, rspRdata_d;

    logic                       cmdAccept;
    logic [SEL_BITS-1:0]        cmdIdx;
    logic                       cmdHit;

    logic                       selReady;
    logic                       selErr;
    logic [DATA_WIDTH-1:0]      selRdata;

    logic                       timeoutHit;

    // Command decode. The index is compared one bit wider than the field
    // so that SLAVES_NUM == 2**SEL_BITS still fits in the constant.
    assign cmdAccept = cmd_valid && cmd_ready;
    assign cmdIdx    = cmd_addr[SEL_LSB +: SEL_BITS];
    assign cmdHit    = ({1'b0, cmdIdx} < (SEL_BITS + 1)'(SLAVES_NUM));

    // Return-path mux: only the slave addressed by the registered index is
    // looked at, so ready, error and data from the other slaves are ignored.
    always_comb begin
        selReady = 1'b0;
        selErr   = 1'b0;
        selRdata = '0;
        for (int i = 0; i < SLAVES_NUM; i++) begin
            if (selIdx_q == SEL_BITS'(i)) begin
                selReady = PREADY[i];
                selErr   = PSLVERR[i];
                selRdata = PRDATA_BUS[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_WIDTH-1:0] timeoutCnt_q, timeoutCnt_d;

    // The counter holds the number of ACCESS cycles already spent without
    // PREADY. The abort therefore fires on the edge that closes the
    // TIMEOUT_CYCLES-th ACCESS cycle. A PREADY on that same cycle takes
    // priority in both the next-state and the output logic.
    assign timeoutHit = (timeoutCnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timeoutCnt_d = timeoutCnt_q;
        if (state_q == SETUP) begin
            timeoutCnt_d = '0;
        end else if ((state_q == ACCESS) && !selReady && !timeoutHit) begin
            timeoutCnt_d = timeoutCnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            timeoutCnt_q <= '0;
        end else begin
            timeoutCnt_q <= timeoutCnt_d;
        end
    end
`else
    // TIMEOUT_CYCLES is never negative, so this is a constant 0 and ACCESS
    // only ends on PREADY. The parameter is still referenced so that both
    // builds share one parameter list.
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A decode miss never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmdAccept && cmdHit) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (selReady || timeoutHit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. The handshake and the bus controls are decoded directly
    // from the state register. The next values of the bus and response
    // registers are computed here from the state and the command/return
    // paths. Reads drive zero write data and strobes. rsp_rdata is zero for
    // writes, errors and aborts, and is only updated when a response is
    // issued.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        PENABLE    = (state_q == ACCESS);
        PSEL       = '0;
        for (int i = 0; i < SLAVES_NUM; i++) begin
            PSEL[i] = (state_q != IDLE) && (selIdx_q == SEL_BITS'(i));
        end

        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pwrite_d   = pwrite_q;
        selIdx_d   = selIdx_q;
        rspValid_d = 1'b0;
        rspErr_d   = rspErr_q;
        rspRdata_d = rspRdata_q;

        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    if (cmdHit) begin
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_write ? cmd_wdata : '0;
                        pstrb_d  = cmd_write ? cmd_strb : '0;
                        selIdx_d = cmdIdx;
                    end else begin
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspRdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (selReady) begin
                    rspValid_d = 1'b1;
                    rspErr_d   = selErr;
                    rspRdata_d = (!pwrite_q && !selErr) ? selRdata : '0;
                end else if (timeoutHit) begin
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b1;
                    rspRdata_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Bus and response registers. Reset clears everything, so a transfer
    // caught by reset drops off the bus and never produces a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            pwrite_q   <= 1'b0;
            selIdx_q   <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            pwrite_q   <= pwrite_d;
            selIdx_q   <= selIdx_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PWRITE    = pwrite_q;
    assign rsp_valid = rspValid_q;
    assign rsp_err   = rspErr_q;
    assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_apb_nslave_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_nslave_bridge
//
// Purpose:
//   Self-checking bench for apb_nslave_bridge with its default parameters
//   (4 slaves, index field at addr[15:12]). A table of directed commands is
//   run through the bridge while the bench plays the slaves. Hand-written
//   sequences cover back-to-back commands, reset during ACCESS and, when
//   APB_TIMEOUT_EN is defined, the ACCESS timeout.
// ---------------------------------------------------------------------------
module tb_apb_nslave_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int NS = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [SW-1:0]     cmd_strb;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic              PWRITE;
    logic              PENABLE;
    logic [NS-1:0]     PSEL;
    logic [NS*DW-1:0]  PRDATA_BUS;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_nslave_bridge dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PRDATA_BUS (PRDATA_BUS),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waitStates;
        logic        slvErr;
        logic [3:0]  expPsel;
        logic [31:0] expPwdata;
        logic [3:0]  expPstrb;
        logic        expErr;
        logic [31:0] expRdata;
        int          expLatency;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every sample and every input change happens 1 ns after a rising edge.
    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Drives one command for a single cycle and sets up the slave side: the
    // other slaves show ready and error so that any leakage is visible, and
    // the target shows the opposite of its final error until it completes.
    task automatic issueCmd(input logic write, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic slvErr);
        int         idx;
        logic [3:0] oneHot;
        idx    = int'(addr[15:12]);
        oneHot = (idx < NS) ? 4'(1 << idx) : 4'b0000;
        PREADY  = ~oneHot;
        PSLVERR = ~oneHot | (slvErr ? 4'b0000 : oneHot);
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
    endtask

    // Plays the target slave until rsp_valid appears or the budget runs out.
    // On return the bench sits in the response cycle. A latency of 0 means
    // no response was seen.
    task automatic waitResponse(input int idx, input int waitStates, input logic slvErr,
                                input int budget, output int latency, output int penCount,
                                output logic [3:0] pselSeen, output logic busStable);
        int          accessCnt;
        logic        done;
        logic        captured;
        logic [31:0] firstAddr;
        logic [3:0]  firstPsel;
        latency   = 0;
        penCount  = 0;
        pselSeen  = 4'b0000;
        busStable = 1'b1;
        accessCnt = 0;
        done      = 1'b0;
        captured  = 1'b0;
        firstAddr = 32'h0;
        firstPsel = 4'h0;
        for (int c = 1; c <= budget && !done; c++) begin
            if (rsp_valid) begin
                latency = c;
                done    = 1'b1;
            end else begin
                pselSeen |= PSEL;
                if (PSEL != 4'b0000) begin
                    if (!captured) begin
                        firstAddr = PADDR;
                        firstPsel = PSEL;
                        captured  = 1'b1;
                    end else if (PADDR !== firstAddr || PSEL !== firstPsel) begin
                        busStable = 1'b0;
                    end
                end
                if (PENABLE) begin
                    penCount++;
                    accessCnt++;
                    if (accessCnt > waitStates && idx < NS) begin
                        PREADY[idx]  = 1'b1;
                        PSLVERR[idx] = slvErr;
                    end
                end
                tick();
            end
        end
    endtask

    task automatic applyStimulus(input int n, input vec_t v);
        int         idx;
        int         lat;
        int         pen;
        logic [3:0] pselSeen;
        logic       stable;
        idx = int'(v.addr[15:12]);
        checkOutput($sformatf("v%0d cmd_ready before", n), 32'(cmd_ready), 32'h1);
        issueCmd(v.write, v.addr, v.wdata, v.strb, v.slvErr);
        if (v.expPsel != 4'b0000) begin
            checkOutput($sformatf("v%0d setup PSEL", n), 32'(PSEL), 32'(v.expPsel));
            checkOutput($sformatf("v%0d setup PENABLE", n), 32'(PENABLE), 32'h0);
            checkOutput($sformatf("v%0d setup PADDR", n), PADDR, v.addr);
            checkOutput($sformatf("v%0d setup PWRITE", n), 32'(PWRITE), 32'(v.write));
            checkOutput($sformatf("v%0d setup PWDATA", n), PWDATA, v.expPwdata);
            checkOutput($sformatf("v%0d setup PSTRB", n), 32'(PSTRB), 32'(v.expPstrb));
        end
        waitResponse(idx, v.waitStates, v.slvErr, 40, lat, pen, pselSeen, stable);
        checkOutput($sformatf("v%0d latency", n), 32'(lat), 32'(v.expLatency));
        checkOutput($sformatf("v%0d PENABLE cycles", n), 32'(pen),
                    (v.expPsel == 4'b0000) ? 32'h0 : 32'(v.waitStates + 1));
        checkOutput($sformatf("v%0d PSEL seen", n), 32'(pselSeen), 32'(v.expPsel));
        checkOutput($sformatf("v%0d bus stable", n), 32'(stable), 32'h1);
        checkOutput($sformatf("v%0d rsp_err", n), 32'(rsp_err), 32'(v.expErr));
        checkOutput($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.expRdata);
        checkOutput($sformatf("v%0d rsp PSEL", n), 32'(PSEL), 32'h0);
        checkOutput($sformatf("v%0d rsp cmd_ready", n), 32'(cmd_ready), 32'h1);
        tick();
        checkOutput($sformatf("v%0d rsp_valid pulse", n), 32'(rsp_valid), 32'h0);
        checkOutput($sformatf("v%0d rsp_err held", n), 32'(rsp_err), 32'(v.expErr));
        checkOutput($sformatf("v%0d rsp_rdata held", n), rsp_rdata, v.expRdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        int         pen;
        logic [3:0] pselSeen;
        logic       stable;
        logic       sawRsp;

        //          write addr          wdata          strb  wait err  PSEL     PWDATA         PSTRB err   rdata          lat
        vecs[0] = '{1'b1, 32'h0000_1004, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 4'b0010, 32'hA5A5_0F0F, 4'hF, 1'b0, 32'h0000_0000, 3};
        vecs[1] = '{1'b0, 32'h0000_2000, 32'h1234_5678, 4'h5, 2, 1'b0, 4'b0100, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF, 5};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1, 1'b1, 4'b0001, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 4};
        vecs[3] = '{1'b1, 32'h0000_7000, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 4'b0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1};
        vecs[4] = '{1'b0, 32'h0000_3FFC, 32'h0000_0000, 4'h0, 0, 1'b0, 4'b1000, 32'h0000_0000, 4'h0, 1'b0, 32'h3333_3333, 3};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_00FF, 4'h1, 3, 1'b1, 4'b0001, 32'h0000_00FF, 4'h1, 1'b1, 32'h0000_0000, 6};
        vecs[6] = '{1'b0, 32'h0001_2000, 32'h0000_0000, 4'h0, 0, 1'b0, 4'b0100, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[7] = '{1'b0, 32'h0000_F000, 32'h0000_0000, 4'h0, 0, 1'b0, 4'b0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1};
        vecs[8] = '{1'b1, 32'h0000_3010, 32'h0BAD_CAFE, 4'hC, 1, 1'b0, 4'b1000, 32'h0BAD_CAFE, 4'hC, 1'b0, 32'h0000_0000, 4};

        PRDATA_BUS = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'hC0DE_0000};
        PREADY     = 4'b0000;
        PSLVERR    = 4'b0000;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        cmd_strb   = 4'h0;
        PRESET     = 1'b1;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset PSEL", 32'(PSEL), 32'h0);
        checkOutput("reset PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("reset PADDR", PADDR, 32'h0);
        checkOutput("reset PWDATA", PWDATA, 32'h0);
        checkOutput("reset PSTRB", 32'(PSTRB), 32'h0);
        checkOutput("reset PWRITE", 32'(PWRITE), 32'h0);
        PRESET = 1'b0;
        tick();

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] back-to-back commands");
        issueCmd(1'b1, 32'h0000_1004, 32'h5555_AAAA, 4'hF, 1'b0);
        waitResponse(1, 0, 1'b0, 40, lat, pen, pselSeen, stable);
        checkOutput("b2b first latency", 32'(lat), 32'h3);
        checkOutput("b2b cmd_ready in rsp cycle", 32'(cmd_ready), 32'h1);
        issueCmd(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b0);
        checkOutput("b2b second setup PSEL", 32'(PSEL), 32'h8);
        checkOutput("b2b second setup PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("b2b rsp_valid dropped", 32'(rsp_valid), 32'h0);
        waitResponse(3, 0, 1'b0, 40, lat, pen, pselSeen, stable);
        checkOutput("b2b second latency", 32'(lat), 32'h3);
        checkOutput("b2b second rdata", rsp_rdata, 32'h3333_3333);
        tick();

        $display("[TB] reset during ACCESS");
        issueCmd(1'b1, 32'h0000_1000, 32'h7777_7777, 4'hF, 1'b0);
        tick();
        checkOutput("rst-mid in ACCESS", 32'(PENABLE), 32'h1);
        PRESET = 1'b1;
        tick();
        checkOutput("rst-mid PSEL", 32'(PSEL), 32'h0);
        checkOutput("rst-mid PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("rst-mid PADDR", PADDR, 32'h0);
        checkOutput("rst-mid PWDATA", PWDATA, 32'h0);
        checkOutput("rst-mid PSTRB", 32'(PSTRB), 32'h0);
        checkOutput("rst-mid PWRITE", 32'(PWRITE), 32'h0);
        checkOutput("rst-mid cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("rst-mid rsp_valid", 32'(rsp_valid), 32'h0);
        PRESET = 1'b0;
        PREADY = 4'b1111;
        sawRsp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            sawRsp |= rsp_valid;
        end
        checkOutput("rst-mid no response", 32'(sawRsp), 32'h0);
        applyStimulus(100, vecs[0]);

`ifdef APB_TIMEOUT_EN
        $display("[TB] ACCESS timeout");
        issueCmd(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
        waitResponse(1, 1000, 1'b0, 40, lat, pen, pselSeen, stable);
        checkOutput("timeout latency", 32'(lat), 32'd18);
        checkOutput("timeout PENABLE cycles", 32'(pen), 32'd16);
        checkOutput("timeout rsp_err", 32'(rsp_err), 32'h1);
        checkOutput("timeout rsp_rdata", rsp_rdata, 32'h0);
        tick();
        checkOutput("timeout bus idle", 32'(PSEL), 32'h0);
        issueCmd(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
        waitResponse(1, 15, 1'b0, 40, lat, pen, pselSeen, stable);
        checkOutput("late ready latency", 32'(lat), 32'd18);
        checkOutput("late ready PENABLE cycles", 32'(pen), 32'd16);
        checkOutput("late ready rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("late ready rsp_rdata", rsp_rdata, 32'h1111_1111);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
